// File: rtl/cla_seq_adder_ctrl.sv
// ============================================================================
// Module      : cla_seq_adder_ctrl (with helper slice carry_lookahead_adder)
// Description : Multi-cycle WIDTH-bit adder/subtractor that reuses a single
//               4-bit carry-lookahead slice over WIDTH/4 cycles, least
//               significant nibble first, with a registered inter-nibble
//               carry. A start/busy/done handshake accepts one operation at
//               a time.
// Ports       : clk   - clock, all state changes on rising edge
//               rst   - synchronous active-high reset
//               start - request, sampled only in IDLE or DONE
//               a, b  - WIDTH-bit operands, captured on accepted start
//               sub   - 1 = A-B, 0 = A+B, captured with operands
//               busy  - high while an operation is running
//               done  - one-cycle pulse when the result is ready
//               sum   - registered result
//               cout  - final carry out (no-borrow flag when subtracting)
//               ovf   - two's-complement signed overflow
// Config      : define CLA_SEQ_SUB_EN to honour the sub input; without it
//               every operation is A+B and the sub port is ignored.
// Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

// ----------------------------------------------------------------------------
// 4-bit carry-lookahead slice: all internal carries are derived directly from
// generate/propagate terms and the carry in, with no ripple between bits.
// ----------------------------------------------------------------------------
module carry_lookahead_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    always_comb begin
        w_g = i_a & i_b;
        w_p = i_a ^ i_b;

        w_c[0] = i_cin;
        w_c[1] = w_g[0] | (w_p[0] & i_cin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & i_cin);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

        o_sum  = w_p ^ w_c[3:0];
        o_cout = w_c[4];
    end

endmodule

// ----------------------------------------------------------------------------
// Sequencing controller
// ----------------------------------------------------------------------------
module cla_seq_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_nibbles = WIDTH / 4;
    localparam int c_kw      = (c_nibbles > 1) ? $clog2(c_nibbles) : 1;

    localparam logic [c_kw-1:0] c_k_last = c_kw'(c_nibbles - 1);
    localparam logic [c_kw-1:0] c_k_one  = c_kw'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [c_kw-1:0]  r_k;
    logic             r_c;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_res;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [1:0]       w_state_nxt;
    logic [c_kw-1:0]  w_k_nxt;
    logic             w_c_nxt;
    logic [WIDTH-1:0] w_opa_nxt;
    logic [WIDTH-1:0] w_opb_nxt;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_a_msb_nxt;
    logic             w_b_msb_nxt;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_cout_nxt;
    logic             w_ovf_nxt;

    // ------------------------------------------------------------------
    // Operand conditioning: subtraction is A + ~B + 1, so the inverted B
    // is stored and the carry register starts at 1.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin0;

`ifdef CLA_SEQ_SUB_EN
    assign w_b_eff = sub ? ~b : b;
    assign w_cin0  = sub;
`else
    // sub is kept on the port for pin compatibility but has no effect.
    logic w_unused_sub;
    assign w_unused_sub = sub;
    assign w_b_eff      = b;
    assign w_cin0       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Shared nibble slice, always fed from the bottom of the operand
    // shift registers.
    // ------------------------------------------------------------------
    logic [3:0]       w_sl_sum;
    logic             w_sl_cout;
    logic [WIDTH-1:0] w_res_shift;

    carry_lookahead_adder u_slice (
        .i_a    (r_opa[3:0]),
        .i_b    (r_opb[3:0]),
        .i_cin  (r_c),
        .o_sum  (w_sl_sum),
        .o_cout (w_sl_cout)
    );

    // Each new nibble enters at the top; after N steps nibble 0 has moved
    // down to bit 0 and the register holds the full result in order.
    assign w_res_shift = {w_sl_sum, r_res[WIDTH-1:4]};

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_c_nxt     = r_c;
        w_opa_nxt   = r_opa;
        w_opb_nxt   = r_opb;
        w_res_nxt   = r_res;
        w_a_msb_nxt = r_a_msb;
        w_b_msb_nxt = r_b_msb;
        w_sum_nxt   = r_sum;
        w_cout_nxt  = r_cout;
        w_ovf_nxt   = r_ovf;

        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_state_nxt = c_st_run;
                    w_opa_nxt   = a;
                    w_opb_nxt   = w_b_eff;
                    w_c_nxt     = w_cin0;
                    w_k_nxt     = '0;
                    // Operand MSBs are lost to shifting, so keep them for
                    // the overflow decision at completion.
                    w_a_msb_nxt = a[WIDTH-1];
                    w_b_msb_nxt = w_b_eff[WIDTH-1];
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end

            c_st_run: begin
                w_res_nxt = w_res_shift;
                w_opa_nxt = {4'b0000, r_opa[WIDTH-1:4]};
                w_opb_nxt = {4'b0000, r_opb[WIDTH-1:4]};
                w_c_nxt   = w_sl_cout;
                w_k_nxt   = r_k + c_k_one;

                if (r_k == c_k_last) begin
                    w_state_nxt = c_st_done;
                    w_k_nxt     = '0;
                    w_sum_nxt   = w_res_shift;
                    w_cout_nxt  = w_sl_cout;
                    // Overflow when both addends share a sign that differs
                    // from the sign of the result (slice MSB is result MSB).
                    w_ovf_nxt   = (r_a_msb == r_b_msb) && (w_sl_sum[3] != r_a_msb);
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_k     <= '0;
            r_c     <= 1'b0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_res   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_c     <= w_c_nxt;
            r_opa   <= w_opa_nxt;
            r_opb   <= w_opb_nxt;
            r_res   <= w_res_nxt;
            r_a_msb <= w_a_msb_nxt;
            r_b_msb <= w_b_msb_nxt;
            r_sum   <= w_sum_nxt;
            r_cout  <= w_cout_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy = (r_state == c_st_run);
    assign done = (r_state == c_st_done);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

`default_nettype wire
